kos_serial_add32: RTL and testbench

KOS_SERIAL_ADD32 -- requirements
Module: kos_serial_add32

---
 rtl/kos_pkg.sv | 14 +
 rtl/kos_adder_8.sv | 25 ++
 rtl/kos_serial_add32.sv | 117 +++++++++++
 tb/tb_kos_serial_add32.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/kos_pkg.sv
// rtl/kos_pkg.sv - shared slice width, NUM_BYTES bounds and FSM state type for the serial adder
package kos_pkg;

    localparam int SLICE_W       = 8;
    localparam int NUM_BYTES_MIN = 2;
    localparam int NUM_BYTES_MAX = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } kos_state_t;

endpackage

// File: rtl/kos_adder_8.sv
// rtl/kos_adder_8.sv - combinational 8-bit slice adder with carry-out and carry into the slice MSB
module kos_adder_8
    import kos_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] sum,
    output logic               co,
    output logic               c_msb
);

    logic [SLICE_W:0]   full;
    logic [SLICE_W-1:0] low;

    assign full = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, ci};

    // Adding only the lower bits exposes the carry into the top bit, needed for signed overflow.
    assign low  = {1'b0, a[SLICE_W-2:0]} + {1'b0, b[SLICE_W-2:0]} + {{(SLICE_W-1){1'b0}}, ci};

    assign sum   = full[SLICE_W-1:0];
    assign co    = full[SLICE_W];
    assign c_msb = low[SLICE_W-1];

endmodule

// File: rtl/kos_serial_add32.sv
// rtl/kos_serial_add32.sv - byte-serial adder top; KOS_SERIAL_ADD32_SUB_EN adds a sub input for a - b
module kos_serial_add32
    import kos_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SLICE_W*NUM_BYTES-1:0] a,
    input  logic [SLICE_W*NUM_BYTES-1:0] b,
    input  logic                         ci,
`ifdef KOS_SERIAL_ADD32_SUB_EN
    input  logic                         sub,
`endif
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SLICE_W*NUM_BYTES-1:0] s,
    output logic                         co,
    output logic                         ovf
);

    localparam int W     = SLICE_W * NUM_BYTES;
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    // An out-of-range NUM_BYTES refers to a module that does not exist, stopping elaboration.
    generate
        if (NUM_BYTES < NUM_BYTES_MIN || NUM_BYTES > NUM_BYTES_MAX) begin : g_bad_num_bytes
            kos_serial_add32_num_bytes_out_of_range u_bad ();
        end
    endgenerate

    kos_state_t state_q, state_d;

    logic [W-1:0]       a_q, b_q, s_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q, co_q, ovf_q;
    logic [W-1:0]       b_eff;
    logic               c_eff;
    logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
    logic               slice_co, slice_c_msb;
    logic               accept;

`ifdef KOS_SERIAL_ADD32_SUB_EN
    // Subtraction is a + ~b + 1, so b is inverted at latch time and ci is replaced by 1.
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? 1'b1 : ci;
`else
    assign b_eff = b;
    assign c_eff = ci;
`endif

    assign accept    = in_valid && (state_q == IDLE);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign co        = co_q;
    assign ovf       = ovf_q;

    assign slice_a = a_q[idx_q*SLICE_W +: SLICE_W];
    assign slice_b = b_q[idx_q*SLICE_W +: SLICE_W];

    kos_adder_8 u_adder (
        .a     (slice_a),
        .b     (slice_b),
        .ci    (carry_q),
        .sum   (slice_sum),
        .co    (slice_co),
        .c_msb (slice_c_msb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)            state_d = RUN;
            RUN:     if (idx_q == LAST_IDX)   state_d = DONE;
            DONE:    if (out_ready)           state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b_eff;
            carry_q <= c_eff;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            s_q[idx_q*SLICE_W +: SLICE_W] <= slice_sum;
            carry_q <= slice_co;
            idx_q   <= idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
                co_q  <= slice_co;
                ovf_q <= slice_c_msb ^ slice_co;
            end
        end
    end

endmodule

// File: tb/tb_kos_serial_add32.sv
// tb/tb_kos_serial_add32.sv - randomized scoreboard bench for kos_serial_add32 against an arithmetic model
module tb_kos_serial_add32;

    localparam int NB = 4;
    localparam int W  = 8 * NB;
    localparam longint MAXS = (longint'(1) << (W - 1)) - 1;
    localparam longint MINS = -(longint'(1) << (W - 1));

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         ci = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
`ifdef KOS_SERIAL_ADD32_SUB_EN
    logic         sub = 1'b0;
`endif
    logic         in_ready, out_valid, co, ovf;
    logic [W-1:0] s;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   stall_left = 0;
    bit   rand_ready = 0;
    bit   prev_valid = 0;
    bit   took = 0;

    kos_serial_add32 #(.NUM_BYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
`ifdef KOS_SERIAL_ADD32_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(logic [W-1:0] aa, logic [W-1:0] bb, logic cc, bit sb);
        exp_t        e;
        logic [W:0]  u;
        longint      sr;
        if (sb) begin
            e.s  = aa - bb;
            e.co = (aa >= bb);
            sr   = longint'($signed(aa)) - longint'($signed(bb));
        end else begin
            u    = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, cc};
            e.s  = u[W-1:0];
            e.co = u[W];
            sr   = longint'($signed(aa)) + longint'($signed(bb)) + longint'(cc);
        end
        e.ovf = (sr > MAXS) || (sr < MINS);
        e.acc = 0;
        return e;
    endfunction

    task automatic do_op(logic [W-1:0] aa, logic [W-1:0] bb, logic cc, bit sb, int stall);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        stall_left = stall;
        in_valid = 1'b1;
        a  = aa;
        b  = bb;
        ci = cc;
`ifdef KOS_SERIAL_ADD32_SUB_EN
        sub = sb;
`endif
        @(posedge clk);
        #1;
        e = model(aa, bb, cc, sb);
        e.acc = cyc;
        sbq.push_back(e);
        // Scramble operands while busy; the latched copies must be what gets summed.
        in_valid = 1'b0;
        a  = $urandom;
        b  = $urandom;
        ci = 1'($urandom_range(0, 1));
`ifdef KOS_SERIAL_ADD32_SUB_EN
        sub = 1'($urandom_range(0, 1));
`endif
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 0;
            took = 0;
            out_ready = 1'b0;
        end else begin
            if (took) begin
                chk("in_ready_after_take", 64'(in_ready), 64'd1);
                chk("out_valid_after_take", 64'(out_valid), 64'd0);
                took = 0;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                if (out_valid) stall_left--;
            end else begin
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (out_valid) begin
                chk("in_ready_in_done", 64'(in_ready), 64'd0);
                if (sbq.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    if (!prev_valid)
                        chk("latency", 64'(cyc - sbq[0].acc), 64'(NB));
                    chk("s", 64'(s), 64'(sbq[0].s));
                    chk("co", 64'(co), 64'(sbq[0].co));
                    chk("ovf", 64'(ovf), 64'(sbq[0].ovf));
                    if (out_ready) void'(sbq.pop_front());
                end
                if (out_ready) took = 1;
            end
            prev_valid = out_valid && !out_ready;
        end
    end

    initial begin
        int t;
        bit sb;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_s", 64'(s), 64'd0);
        chk("reset_co", 64'(co), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 0);
        do_op(32'h1234_5678, 32'h1111_1111, 1'b1, 0, 0);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 0);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, 5);

        // Reset two RUN edges into an operation: it must vanish without output.
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        in_valid = 1'b1;
        a = $urandom;
        b = $urandom;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_reset_out_valid", 64'(out_valid), 64'd0);
        chk("midrun_reset_in_ready", 64'(in_ready), 64'd1);
        chk("midrun_reset_s", 64'(s), 64'd0);
        chk("midrun_reset_co", 64'(co), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'd3, 32'd4, 1'b0, 0, 0);

`ifdef KOS_SERIAL_ADD32_SUB_EN
        do_op(32'd5, 32'd7, 1'b1, 1, 0);
        do_op(32'd7, 32'd5, 1'b0, 1, 0);
        do_op(32'h8000_0000, 32'd1, 1'b0, 1, 0);
`endif

        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            sb = 0;
`ifdef KOS_SERIAL_ADD32_SUB_EN
            sb = 1'($urandom_range(0, 1));
`endif
            do_op($urandom, $urandom, 1'($urandom_range(0, 1)), sb,
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        t = 0;
        while (sbq.size() != 0 && t < 500) begin
            @(posedge clk);
            t++;
        end
        chk("drain_pending", 64'(sbq.size()), 64'd0);
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
